adc_window_capture: RTL

- Sits directly downstream of the 14-bit ADC sampling stage and consumes its registered sample plus valid strobe.
- Once armed, it waits for a rising-edge level trigger, then captures FRAME_LEN consecutive valid samples into on-chip RAM.
- It then streams the frame out on an AXI-Stream master to the wavelet transform stage, sign-extended to OUT_WIDTH, with tlast on the final sample.

---
 rtl/adc_window_pkg.sv | 23 ++
 rtl/adc_window_ram.sv | 26 ++
 rtl/adc_window_capture.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/adc_window_pkg.sv
// Shared state encoding, default widths and sign-extension helper for adc_window_capture.
package adc_window_pkg;

    localparam int ADC_WIDTH_DEF = 14;
    localparam int OUT_WIDTH_DEF = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_WAIT_TRIG = 2'd1;
    localparam state_t ST_CAPTURE   = 2'd2;
    localparam state_t ST_DRAIN     = 2'd3;

    // Replicates bit w-1 of v into every higher bit; callers cast down to their own width.
    function automatic logic [31:0] sign_extend(input logic [31:0] v, input int w);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = (i < w) ? v[i] : v[w-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/adc_window_ram.sv
// Simple dual-port frame store (1 write, 1 registered read port), read data one cycle after re_i.
module adc_window_ram #(
    parameter int DATA_WIDTH = 14,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/adc_window_capture.sv
// Armed rising-level trigger captures FRAME_LEN samples, replayed on AXI-S; ADC_WINDOW_DECIM2_EN averages pairs.
// First beat within 3 cycles of DRAIN, then 1 beat/clk; tready stalls hold a 2-entry skid, RAM reads throttle.
module adc_window_capture
    import adc_window_pkg::*;
#(
    parameter int ADC_WIDTH  = ADC_WIDTH_DEF,
    parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
    parameter int FRAME_LEN  = 1024,
    parameter int ADDR_WIDTH = $clog2(FRAME_LEN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADC_WIDTH-1:0] adc_data_in,
    input  logic                 adc_data_valid,
    input  logic                 arm,
    input  logic [ADC_WIDTH-1:0] trig_level,
    output logic [OUT_WIDTH-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 busy,
    output logic                 dropped
);

    localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'(FRAME_LEN - 1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);

    state_t               state_q, state_d;
    logic [ADC_WIDTH-1:0] level_q, prev_q;
    logic                 prev_vld_q, dropped_q;
    logic [ADDR_WIDTH:0]  wr_cnt_q, rd_cnt_q;

    logic                 ram_we, ram_re;
    logic [ADC_WIDTH-1:0] ram_wdata, ram_rdata;

    logic                 pend_q, pend_last_q;
    logic [ADC_WIDTH-1:0] sk_dat_q [2];
    logic [1:0]           sk_last_q;
    logic                 sk_wp_q, sk_rp_q;
    logic [1:0]           sk_cnt_q;
    logic [2:0]           sk_occ;
    logic                 pop, trig_hit;

`ifdef ADC_WINDOW_DECIM2_EN
    logic [ADC_WIDTH-1:0]      hold_q;
    logic                      half_q;
    logic signed [ADC_WIDTH:0] pair_sum;
    logic [ADC_WIDTH-1:0]      pair_avg;

    assign pair_sum = $signed({hold_q[ADC_WIDTH-1], hold_q})
                    + $signed({adc_data_in[ADC_WIDTH-1], adc_data_in});
    assign pair_avg = ADC_WIDTH'(pair_sum >>> 1);
`endif

    assign trig_hit = adc_data_valid && prev_vld_q
                   && ($signed(prev_q) < $signed(level_q))
                   && ($signed(adc_data_in) >= $signed(level_q));

    assign m_axis_tvalid = (sk_cnt_q != 2'd0);
    assign pop           = m_axis_tvalid && m_axis_tready;
    // Occupancy the skid will hold next cycle; a new read is only issued if its data has a slot.
    assign sk_occ        = 3'(sk_cnt_q) + 3'(pend_q) - 3'(pop);
    assign ram_re        = (state_q == ST_DRAIN) && (rd_cnt_q <= LAST_ADDR) && (sk_occ < 3'd2);

    assign m_axis_tdata = m_axis_tvalid
                        ? OUT_WIDTH'(sign_extend(32'(sk_dat_q[sk_rp_q]), ADC_WIDTH)) : '0;
    assign m_axis_tlast = m_axis_tvalid && sk_last_q[sk_rp_q];
    assign busy         = (state_q != ST_IDLE);
    assign dropped      = dropped_q;

    always_comb begin
        ram_we    = 1'b0;
        ram_wdata = adc_data_in;
`ifdef ADC_WINDOW_DECIM2_EN
        if (state_q == ST_CAPTURE) begin
            ram_we    = adc_data_valid && half_q;
            ram_wdata = pair_avg;
        end
`else
        if (state_q == ST_WAIT_TRIG) begin
            ram_we = trig_hit;
        end else if (state_q == ST_CAPTURE) begin
            ram_we = adc_data_valid;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (arm) state_d = ST_WAIT_TRIG;
            ST_WAIT_TRIG: if (trig_hit) state_d = ST_CAPTURE;
            ST_CAPTURE:   if (ram_we && (wr_cnt_q == LAST_ADDR)) state_d = ST_DRAIN;
            ST_DRAIN:     if (m_axis_tlast && m_axis_tready) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            level_q     <= '0;
            prev_q      <= '0;
            prev_vld_q  <= 1'b0;
            dropped_q   <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            sk_last_q   <= '0;
            sk_wp_q     <= 1'b0;
            sk_rp_q     <= 1'b0;
            sk_cnt_q    <= '0;
`ifdef ADC_WINDOW_DECIM2_EN
            hold_q      <= '0;
            half_q      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && arm) begin
                level_q    <= trig_level;
                prev_vld_q <= 1'b0;
                dropped_q  <= 1'b0;
                wr_cnt_q   <= '0;
                rd_cnt_q   <= '0;
            end
            if ((state_q == ST_WAIT_TRIG) && adc_data_valid && !trig_hit) begin
                prev_q     <= adc_data_in;
                prev_vld_q <= 1'b1;
            end
`ifdef ADC_WINDOW_DECIM2_EN
            if ((state_q == ST_WAIT_TRIG) && trig_hit) begin
                hold_q <= adc_data_in;
                half_q <= 1'b1;
            end else if ((state_q == ST_CAPTURE) && adc_data_valid) begin
                if (!half_q) begin
                    hold_q <= adc_data_in;
                end
                half_q <= !half_q;
            end
`endif
            if (ram_we) begin
                wr_cnt_q <= wr_cnt_q + CNT_ONE;
            end
            if ((state_q == ST_DRAIN) && adc_data_valid) begin
                dropped_q <= 1'b1;
            end
            if (ram_re) begin
                rd_cnt_q <= rd_cnt_q + CNT_ONE;
            end
            pend_q      <= ram_re;
            pend_last_q <= (rd_cnt_q == LAST_ADDR);
            if (pend_q) begin
                sk_last_q[sk_wp_q] <= pend_last_q;
                sk_wp_q            <= ~sk_wp_q;
            end
            if (pop) begin
                sk_rp_q <= ~sk_rp_q;
            end
            sk_cnt_q <= sk_occ[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (pend_q) begin
            sk_dat_q[sk_wp_q] <= ram_rdata;
        end
    end

    adc_window_ram #(
        .DATA_WIDTH (ADC_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wr_cnt_q[ADDR_WIDTH-1:0]),
        .wdata_i (ram_wdata),
        .re_i    (ram_re),
        .raddr_i (rd_cnt_q[ADDR_WIDTH-1:0]),
        .rdata_o (ram_rdata)
    );

endmodule
